// File: rtl/core_halt_monitor.sv
// Passive pipeline observer: detects the terminating self-loop with decode empty,
// and keeps cycle / retired-instruction / stall counters that freeze once halted.
module core_halt_monitor #(
  parameter int          CNT_WIDTH    = 32,
  parameter int          HALT_CONFIRM = 2,
  parameter logic [31:0] HALT_INSTR   = 32'h0000006F,
  parameter logic [31:0] BUBBLE_INSTR = 32'h00000000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          fetch_instr,
  input  logic [31:0]          decode_instr,
  input  logic                 decode_valid,
  input  logic                 stall,
  input  logic                 clear,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] cycles,
  output logic [CNT_WIDTH-1:0] instret,
  output logic [CNT_WIDTH-1:0] stall_cycles,
  output logic                 overflow
);

  typedef enum logic [1:0] {RUN, ARMED, HALTED} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [3:0]           HC4     = HALT_CONFIRM[3:0];

  state_t                 state_q;
  logic [3:0]             conf_q;
  logic [CNT_WIDTH-1:0]   mark_q;
  logic                   halted_q, overflow_q;
  logic [CNT_WIDTH-1:0]   cycles_q, instret_q, stall_q;

  logic                   match, ins_evt, halt_now;
  logic                   cyc_sat, ins_sat, stl_sat;
  logic [CNT_WIDTH-1:0]   cycles_d, instret_d, stall_d;
  logic                   overflow_d;

  always_comb begin
    match    = (fetch_instr == HALT_INSTR) && (decode_instr == BUBBLE_INSTR);
    ins_evt  = decode_valid && !stall && (decode_instr != BUBBLE_INSTR);
    halt_now = match && (((state_q == RUN) && (HALT_CONFIRM == 1)) ||
                         ((state_q == ARMED) && ((conf_q + 4'd1) == HC4)));
    cyc_sat  = (cycles_q == CNT_MAX);
    ins_sat  = (instret_q == CNT_MAX);
    stl_sat  = (stall_q == CNT_MAX);

    // On the halting edge cycles is rewound to the count before the loop was first seen.
    if (halt_now)
      cycles_d = (state_q == RUN) ? cycles_q : mark_q;
    else
      cycles_d = cyc_sat ? cycles_q : cycles_q + CNT_ONE;
    instret_d  = (ins_evt && !ins_sat) ? instret_q + CNT_ONE : instret_q;
    stall_d    = (stall && !stl_sat) ? stall_q + CNT_ONE : stall_q;
    overflow_d = overflow_q | (!halt_now && cyc_sat) | (ins_evt && ins_sat) | (stall && stl_sat);
  end

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      state_q    <= RUN;
      conf_q     <= 4'd0;
      mark_q     <= '0;
      halted_q   <= 1'b0;
      overflow_q <= 1'b0;
      cycles_q   <= '0;
      instret_q  <= '0;
      stall_q    <= '0;
    end else if (state_q != HALTED) begin
      cycles_q   <= cycles_d;
      instret_q  <= instret_d;
      stall_q    <= stall_d;
      overflow_q <= overflow_d;
      if (halt_now) begin
        state_q  <= HALTED;
        halted_q <= 1'b1;
      end else begin
        unique case (state_q)
          RUN: begin
            if (match) begin
              state_q <= ARMED;
              mark_q  <= cycles_q;
              conf_q  <= 4'd1;
            end
          end
          ARMED: begin
            if (match) begin
              conf_q <= conf_q + 4'd1;
            end else begin
              state_q <= RUN;
              conf_q  <= 4'd0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign halted       = halted_q;
  assign cycles       = cycles_q;
  assign instret      = instret_q;
  assign stall_cycles = stall_q;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_core_halt_monitor.sv
// Bench for core_halt_monitor: three parameterisations share one stimulus stream
// and are each compared every edge against a streak-based reference model.
module tb_core_halt_monitor;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] fetch_instr = '0;
  logic [31:0] decode_instr = '0;
  logic        decode_valid = 1'b0;
  logic        stall = 1'b0;
  logic        clear = 1'b0;

  logic        a_halted, b_halted, c_halted;
  logic        a_ovf, b_ovf, c_ovf;
  logic [31:0] a_cyc, a_ins, a_stl, c_cyc, c_ins, c_stl;
  logic [3:0]  b_cyc, b_ins, b_stl;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  core_halt_monitor #(.CNT_WIDTH(32), .HALT_CONFIRM(2)) u_a (
    .clk(clk), .rst(rst), .fetch_instr(fetch_instr), .decode_instr(decode_instr),
    .decode_valid(decode_valid), .stall(stall), .clear(clear), .halted(a_halted),
    .cycles(a_cyc), .instret(a_ins), .stall_cycles(a_stl), .overflow(a_ovf));

  core_halt_monitor #(.CNT_WIDTH(4), .HALT_CONFIRM(2)) u_b (
    .clk(clk), .rst(rst), .fetch_instr(fetch_instr), .decode_instr(decode_instr),
    .decode_valid(decode_valid), .stall(stall), .clear(clear), .halted(b_halted),
    .cycles(b_cyc), .instret(b_ins), .stall_cycles(b_stl), .overflow(b_ovf));

  core_halt_monitor #(.CNT_WIDTH(32), .HALT_CONFIRM(1)) u_c (
    .clk(clk), .rst(rst), .fetch_instr(fetch_instr), .decode_instr(decode_instr),
    .decode_valid(decode_valid), .stall(stall), .clear(clear), .halted(c_halted),
    .cycles(c_cyc), .instret(c_ins), .stall_cycles(c_stl), .overflow(c_ovf));

  typedef struct {
    bit     halted;
    longint cyc, ins, stl;
    bit     ovf;
    int     streak;
    longint start;
  } mdl_t;

  mdl_t ma, mb, mc;

  // Reference: count consecutive matching edges; halt when the streak reaches the
  // confirm depth, reporting the cycle count seen when the streak began.
  function automatic mdl_t mstep(mdl_t m, bit rstn, bit clr, bit mt, bit ci, bit st,
                                 longint maxv, int hc);
    mdl_t n;
    n = m;
    if (!rstn || clr) begin
      n.halted = 0; n.cyc = 0; n.ins = 0; n.stl = 0; n.ovf = 0; n.streak = 0; n.start = 0;
      return n;
    end
    if (m.halted) return n;
    if (mt) begin
      if (m.streak == 0) n.start = m.cyc;
      n.streak = m.streak + 1;
    end else begin
      n.streak = 0;
    end
    if (ci) begin
      if (m.ins == maxv) n.ovf = 1; else n.ins = m.ins + 1;
    end
    if (st) begin
      if (m.stl == maxv) n.ovf = 1; else n.stl = m.stl + 1;
    end
    if (mt && n.streak == hc) begin
      n.halted = 1;
      n.cyc = n.start;
    end else if (m.cyc == maxv) begin
      n.ovf = 1;
    end else begin
      n.cyc = m.cyc + 1;
    end
    return n;
  endfunction

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    bit mt, ci;
    @(posedge clk);
    #1;
    mt = (fetch_instr == 32'h0000006F) && (decode_instr == 32'h0);
    ci = decode_valid && !stall && (decode_instr != 32'h0);
    ma = mstep(ma, rst, clear, mt, ci, stall, 64'hFFFF_FFFF, 2);
    mb = mstep(mb, rst, clear, mt, ci, stall, 64'hF, 2);
    mc = mstep(mc, rst, clear, mt, ci, stall, 64'hFFFF_FFFF, 1);
    chk("a_halted", a_halted, ma.halted); chk("a_cycles", a_cyc, ma.cyc);
    chk("a_instret", a_ins, ma.ins);      chk("a_stall", a_stl, ma.stl);
    chk("a_ovf", a_ovf, ma.ovf);
    chk("b_halted", b_halted, mb.halted); chk("b_cycles", b_cyc, mb.cyc);
    chk("b_instret", b_ins, mb.ins);      chk("b_stall", b_stl, mb.stl);
    chk("b_ovf", b_ovf, mb.ovf);
    chk("c_halted", c_halted, mc.halted); chk("c_cycles", c_cyc, mc.cyc);
    chk("c_instret", c_ins, mc.ins);      chk("c_stall", c_stl, mc.stl);
    chk("c_ovf", c_ovf, mc.ovf);
  endtask

  // fh: fetch holds the loop word; db: decode holds a bubble.
  task automatic set_in(input bit fh, input bit db, input bit dv, input bit st);
    logic [31:0] v;
    v = $urandom;
    if (v == 32'h0000006F) v = v + 32'd1;
    fetch_instr  = fh ? 32'h0000006F : v;
    decode_instr = db ? 32'h0 : ($urandom | 32'h100);
    decode_valid = dv;
    stall        = st;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    ma = '{default: 0}; mb = '{default: 0}; mc = '{default: 0};

    // Reset held with match and stall present
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_in(1, 1, $urandom_range(0, 1), 1);
      tick();
    end
    chk("rst_halted", a_halted, 0);
    chk("rst_cycles", a_cyc, 0);
    chk("rst_stall", a_stl, 0);

    // Basic halt: match from edge 10
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      set_in(0, 0, 1, $urandom_range(0, 1));
      tick();
    end
    set_in(1, 1, 0, 0);
    tick();
    chk("basic_not_yet", a_halted, 0);
    tick();
    chk("basic_halted", a_halted, 1);
    chk("basic_cycles", a_cyc, 10);
    for (int i = 0; i < 20; i++) begin
      set_in($urandom_range(0, 1), $urandom_range(0, 1), 1, 1);
      tick();
    end
    chk("frozen_cycles", a_cyc, 10);

    // Reset while halted
    rst = 1'b0;
    tick();
    chk("rst_halt_clr", a_halted, 0);
    chk("rst_halt_cyc", a_cyc, 0);
    rst = 1'b1;

    // Aborted arm: match at 5, then 12..13
    for (int e = 0; e < 14; e++) begin
      set_in(e == 5 || e >= 12, 1, 0, 0);
      tick();
      if (e == 12) chk("abort_e12", a_halted, 0);
    end
    chk("abort_halted", a_halted, 1);
    chk("abort_cycles", a_cyc, 12);

    // Clear while halted
    do_clear();
    chk("clr_halted", a_halted, 0);
    chk("clr_cycles", a_cyc, 0);

    // Counters: 8 instructions, stalls on 3, then a 2-edge halt
    for (int e = 0; e < 8; e++) begin
      set_in(0, 0, 1, e == 1 || e == 4 || e == 6);
      tick();
    end
    set_in(1, 1, 0, 0);
    tick();
    tick();
    chk("cnt_halted", a_halted, 1);
    chk("cnt_instret", a_ins, 5);
    chk("cnt_stall", a_stl, 3);
    chk("cnt_cycles", a_cyc, 8);

    // Clear coincident with the second match edge cancels the halt
    do_clear();
    set_in(1, 1, 0, 0);
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_match_nohalt", a_halted, 0);
    tick();
    chk("clr_match_first", a_halted, 0);
    tick();
    chk("clr_match_halt", a_halted, 1);
    chk("clr_match_cyc", a_cyc, 0);

    // Saturation of the 4-bit instance
    do_clear();
    for (int i = 0; i < 20; i++) begin
      set_in(0, 0, 0, 0);
      tick();
    end
    chk("sat_cycles", b_cyc, 15);
    chk("sat_ovf", b_ovf, 1);
    chk("sat_wide", a_cyc, 20);
    do_clear();
    chk("sat_clr_cyc", b_cyc, 0);
    chk("sat_clr_ovf", b_ovf, 0);

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(0, 63) != 0);
      clear = ($urandom_range(0, 29) == 0);
      set_in($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
             $urandom_range(0, 1), $urandom_range(0, 2) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/core_halt_monitor.md
# core_halt_monitor

Passive observer beside the CPU pipeline. It consumes the fetch-stage and decode-stage instruction words and detects program termination, i.e. the self-loop `jal x0,0` (`0x0000006F`) in fetch while decode holds a bubble. It keeps cycle, retired-instruction and stall counters that freeze at halt, so benches and SoC status logic read results from registers instead of polling pipeline internals.

## Interface
Parameters:
- CNT_WIDTH, 32, width of every counter output.
- HALT_CONFIRM, 2, consecutive matching cycles required to declare halt (legal range 1..15).
- HALT_INSTR, 32'h0000006F, fetch-stage word that signals termination.
- BUBBLE_INSTR, 32'h00000000, decode-stage word meaning "no instruction".

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  synchronous, active-low reset.
- fetch_instr  in  32  instruction currently output by fetch.
- decode_instr  in  32  instruction currently held in decode.
- decode_valid  in  1  decode holds a real instruction this cycle.
- stall  in  1  pipeline stalled this cycle.
- clear  in  1  synchronous active-high restart of monitor (counters and FSM).
- halted  out  1  program has terminated.
- cycles  out  CNT_WIDTH  cycles executed before termination.
- instret  out  CNT_WIDTH  instructions accepted by decode.
- stall_cycles  out  CNT_WIDTH  cycles with stall asserted.
- overflow  out  1  sticky: some counter saturated.

## Operation
- match = (fetch_instr == HALT_INSTR) && (decode_instr == BUBBLE_INSTR), sampled each rising edge.
- FSM states: RUN, ARMED, HALTED. Confirm counter `conf` is 4 bits. Mark register `mark` is CNT_WIDTH bits.
- RUN:
  - match and HALT_CONFIRM==1 → HALTED, cycles ← current cycles.
  - match otherwise → ARMED, mark ← current cycles (pre-increment), conf ← 1.
  - no match → stay in RUN.
- ARMED:
  - match and conf+1 == HALT_CONFIRM → HALTED, cycles ← mark.
  - match otherwise → conf ← conf+1.
  - no match → RUN, conf ← 0. The mark is discarded.
- HALTED: all counters frozen and halted=1. Leaves only on rst or clear.
- Counting applies on any edge where the pre-edge state is not HALTED and no transition to HALTED occurs on that edge:
  - cycles += 1 every such edge.
  - instret += 1 when decode_valid && !stall && decode_instr != BUBBLE_INSTR.
  - stall_cycles += 1 when stall.
- On the edge entering HALTED, instret and stall_cycles still update from that edge's inputs. cycles is overwritten as above.
- Arithmetic is unsigned. Each counter saturates at all-ones and does not wrap. overflow ← 1 on any attempted increment past all-ones, and stays set until rst or clear.
- Priority: rst > clear > FSM/counters. A clear coincident with match ignores the match. The next edge with clear low starts fresh in RUN.
- Inputs carrying X/Z are not checked.

## Timing
- Reset value: all outputs 0, state RUN, conf 0, mark 0. rst is held low for ≥1 edge. An rst asserted mid-ARMED or in HALTED returns to RUN on that edge.
- All outputs are registered and change only on rising edges. Latency is one edge from the sampled input to the visible output.
- Cycle numbering: edge 0 is the first edge with rst high. cycles reads n after edge n-1.
- If match is first sampled at edge k and holds through edge k+HALT_CONFIRM-1:
  - halted=1 after that last edge.
  - cycles = k, the cycle count before the loop instruction reached fetch with decode empty.
- clear acts like reset for state and counters. It does not require rst.

## Test plan
- Reset: rst=0 for 3 edges with match=1, stall=1 and random instructions → halted=0, all counters 0, overflow=0. Hold rst=0 while HALTED → outputs return to 0 on the next edge.
- Basic halt (HALT_CONFIRM=2): no match on edges 0–9, match from edge 10 on → halted=1 after edge 11, cycles=10. All outputs remain constant for 20 further edges.
- Aborted arm: match only at edge 5, then at edges 12–13 → halted=0 through edge 12, halted=1 after edge 13, cycles=12.
- Counters: 8 edges of decode_valid=1 with nonzero decode_instr, stall=1 on 3 of them, then halt → instret=5, stall_cycles=3 (plus any counts from the confirm edges, computed per the rules).
- Saturation (CNT_WIDTH=4): 20 edges, no match → cycles=15, overflow=1. Then clear=1 → cycles=0, overflow=0 after that edge.
- Clear interactions: clear=1 while HALTED → halted=0, counters 0 next edge. clear=1 coincident with the second match edge → no halt. Halt then needs 2 new match edges after clear drops.
